// File: rtl/imem_load_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imem_load_ctrl_pkg
// Description : Shared constants for the instruction-RAM load controller.
// Revision    : 1.0 - initial release
// ============================================================================
package imem_load_ctrl_pkg;

    localparam int          c_bytes_per_word = 4;
    localparam logic [31:0] c_halt_word      = 32'hFFFF_FFFF;

    localparam int             c_state_w  = 3;
    localparam logic [2:0]     c_st_idle    = 3'd0;
    localparam logic [2:0]     c_st_collect = 3'd1;
    localparam logic [2:0]     c_st_write   = 3'd2;
    localparam logic [2:0]     c_st_run     = 3'd3;
    localparam logic [2:0]     c_st_error   = 3'd4;

endpackage
`default_nettype wire

// File: rtl/imem_load_ctrl_byte_word_assembler.sv
`default_nettype none
// ============================================================================
// Module      : imem_load_ctrl_byte_word_assembler
// Description : Big-endian byte-to-word shift register with a byte counter.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_load_ctrl_byte_word_assembler
    import imem_load_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                                   i_clk,
    input  logic                                   i_rst_n,
    input  logic                                   i_clear,
    input  logic                                   i_accept,
    input  logic                                   i_valid,
    input  logic [DATA_WIDTH-1:0]                  i_byte,
    output logic [c_bytes_per_word*DATA_WIDTH-1:0] o_word,
    output logic                                   o_word_ready
);

    localparam int c_word_w = c_bytes_per_word * DATA_WIDTH;

    logic [c_word_w-1:0] r_word;
    logic [1:0]          r_cnt;
    logic                w_take;

    // A clear in the same cycle as a byte drops that byte.
    assign w_take       = i_accept & i_valid & ~i_clear;
    assign o_word_ready = w_take & (r_cnt == 2'd3);
    assign o_word       = r_word;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_word <= '0;
            r_cnt  <= 2'd0;
        end else if (i_clear) begin
            r_word <= '0;
            r_cnt  <= 2'd0;
        end else if (w_take) begin
            r_word <= {r_word[c_word_w-DATA_WIDTH-1:0], i_byte};
            r_cnt  <= r_cnt + 2'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/imem_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : imem_load_ctrl
// Description : Loads a UART byte stream into instruction RAM, then hands the
//               RAM address port to the CPU fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_load_ctrl
    import imem_load_ctrl_pkg::*;
#(
    parameter int                                   ADDR_WIDTH = 12,
    parameter int                                   DATA_WIDTH = 8,
    parameter logic [c_bytes_per_word*DATA_WIDTH-1:0] HALT_WORD  = c_halt_word
) (
    input  logic                                   i_clk,
    input  logic                                   i_rst_n,
    input  logic                                   i_start_load,
    input  logic [DATA_WIDTH-1:0]                  i_rx_data,
    input  logic                                   i_rx_valid,
    input  logic [ADDR_WIDTH-1:0]                  i_cpu_addr,
    output logic                                   o_mem_we,
    output logic [ADDR_WIDTH-1:0]                  o_mem_addr,
    output logic [c_bytes_per_word*DATA_WIDTH-1:0] o_mem_wdata,
    output logic                                   o_cpu_stall,
    output logic                                   o_load_done,
    output logic                                   o_load_error,
    output logic [ADDR_WIDTH-2:0]                  o_word_count
);

    localparam int                    c_word_w   = c_bytes_per_word * DATA_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] c_last_ptr = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};
    localparam logic [ADDR_WIDTH-1:0] c_ptr_step = ADDR_WIDTH'(c_bytes_per_word);
    localparam logic [ADDR_WIDTH-2:0] c_cnt_one  = (ADDR_WIDTH-1)'(1);

    logic [c_state_w-1:0]  r_state;
    logic [c_state_w-1:0]  w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [ADDR_WIDTH-2:0] r_word_count;
    logic [c_word_w-1:0]   w_word;
    logic                  w_word_ready;
    logic                  w_accept;
    logic                  w_is_halt;
    logic                  w_at_last;

    // The byte arriving in the WRITE cycle already belongs to the next word.
    assign w_accept  = (r_state == c_st_collect) | (r_state == c_st_write);
    assign w_is_halt = (w_word == HALT_WORD);
    assign w_at_last = (r_ptr == c_last_ptr);

    imem_load_ctrl_byte_word_assembler #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_assembler (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_clear      (i_start_load),
        .i_accept     (w_accept),
        .i_valid      (i_rx_valid),
        .i_byte       (i_rx_data),
        .o_word       (w_word),
        .o_word_ready (w_word_ready)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:    w_state_nxt = c_st_idle;
            c_st_collect: if (w_word_ready) w_state_nxt = c_st_write;
            c_st_write: begin
                if (w_is_halt) begin
                    w_state_nxt = c_st_run;
                end else if (w_at_last) begin
                    w_state_nxt = c_st_error;
                end else begin
                    w_state_nxt = c_st_collect;
                end
            end
            c_st_run:     w_state_nxt = c_st_run;
            c_st_error:   w_state_nxt = c_st_error;
            default:      w_state_nxt = c_st_idle;
        endcase
        if (i_start_load) begin
            w_state_nxt = c_st_collect;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr        <= '0;
            r_word_count <= '0;
        end else if (i_start_load) begin
            r_ptr        <= '0;
            r_word_count <= '0;
        end else if (r_state == c_st_write) begin
            r_word_count <= r_word_count + c_cnt_one;
            // The pointer stays on the last written word when the load ends.
            if (!w_is_halt && !w_at_last) begin
                r_ptr <= r_ptr + c_ptr_step;
            end
        end
    end

    assign o_mem_we     = (r_state == c_st_write);
    assign o_mem_addr   = (r_state == c_st_run) ? i_cpu_addr : r_ptr;
    assign o_mem_wdata  = w_word;
    assign o_cpu_stall  = (r_state != c_st_run);
    assign o_load_done  = (r_state == c_st_run);
    assign o_load_error = (r_state == c_st_error);
    assign o_word_count = r_word_count;

endmodule
`default_nettype wire

// File: tb/tb_imem_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_load_ctrl
// Description : Directed bench for imem_load_ctrl with a RAM-write scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_load_ctrl;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk;
    logic        rst_n;
    logic        start_load;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [11:0] cpu_addr_b;
    logic [3:0]  cpu_addr_s;

    logic        we_b,   we_s;
    logic [11:0] addr_b;
    logic [3:0]  addr_s;
    logic [31:0] wdata_b, wdata_s;
    logic        stall_b, stall_s;
    logic        done_b,  done_s;
    logic        err_b,   err_s;
    logic [10:0] wc_b;
    logic [2:0]  wc_s;

    int  total = 0;
    int  bad   = 0;
    wr_t q_b[$];
    wr_t q_s[$];

    imem_load_ctrl #(.ADDR_WIDTH(12)) u_dut_big (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start_load (start_load),
        .i_rx_data    (rx_data),
        .i_rx_valid   (rx_valid),
        .i_cpu_addr   (cpu_addr_b),
        .o_mem_we     (we_b),
        .o_mem_addr   (addr_b),
        .o_mem_wdata  (wdata_b),
        .o_cpu_stall  (stall_b),
        .o_load_done  (done_b),
        .o_load_error (err_b),
        .o_word_count (wc_b)
    );

    imem_load_ctrl #(.ADDR_WIDTH(4)) u_dut_small (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start_load (start_load),
        .i_rx_data    (rx_data),
        .i_rx_valid   (rx_valid),
        .i_cpu_addr   (cpu_addr_s),
        .o_mem_we     (we_s),
        .o_mem_addr   (addr_s),
        .o_mem_wdata  (wdata_s),
        .o_cpu_stall  (stall_s),
        .o_load_done  (done_s),
        .o_load_error (err_s),
        .o_word_count (wc_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic pulse_start();
        start_load = 1'b1;
        tick();
        start_load = 1'b0;
    endtask

    task automatic expect_both(input logic [31:0] a, input logic [31:0] d);
        q_b.push_back('{addr: a, data: d});
        q_s.push_back('{addr: a, data: d});
    endtask

    // Scoreboards: every RAM write must match the oldest expected write.
    always @(negedge clk) begin
        if (we_b) begin
            total++;
            assert (q_b.size() != 0) else begin
                bad++;
                $error("FAIL big_unexpected_write observed=%h/%h expected=none", addr_b, wdata_b);
            end
            if (q_b.size() != 0) begin
                wr_t e;
                e = q_b.pop_front();
                chk("big_wr_addr", {20'd0, addr_b}, e.addr);
                chk("big_wr_data", wdata_b, e.data);
            end
        end
    end

    always @(negedge clk) begin
        if (we_s) begin
            total++;
            assert (q_s.size() != 0) else begin
                bad++;
                $error("FAIL small_unexpected_write observed=%h/%h expected=none", addr_s, wdata_s);
            end
            if (q_s.size() != 0) begin
                wr_t e;
                e = q_s.pop_front();
                chk("small_wr_addr", {28'd0, addr_s}, e.addr);
                chk("small_wr_data", wdata_s, e.data);
            end
        end
    end

    initial begin
        rst_n      = 1'b0;
        start_load = 1'b0;
        rx_data    = 8'h00;
        rx_valid   = 1'b0;
        cpu_addr_b = 12'h000;
        cpu_addr_s = 4'h0;

        // Reset, then idle bytes that must be ignored
        repeat (3) tick();
        rst_n = 1'b1;
        send_byte(8'h5A);
        tick();
        @(negedge clk);
        chk("rst_stall", {31'd0, stall_b}, 32'd1);
        chk("rst_done",  {31'd0, done_b},  32'd0);
        chk("rst_error", {31'd0, err_b},   32'd0);
        chk("rst_we",    {31'd0, we_b},    32'd0);
        chk("rst_wc",    {21'd0, wc_b},    32'd0);
        chk("rst_stall_s", {31'd0, stall_s}, 32'd1);

        // Single word, stays in COLLECT
        pulse_start();
        expect_both(32'h0, 32'h1234_5678);
        send_word(32'h1234_5678);
        tick();
        @(negedge clk);
        chk("w1_wc",    {21'd0, wc_b}, 32'd1);
        chk("w1_stall", {31'd0, stall_b}, 32'd1);
        chk("w1_done",  {31'd0, done_b},  32'd0);

        // Back-to-back words ending in the halt marker
        pulse_start();
        @(negedge clk);
        chk("restart_wc", {21'd0, wc_b}, 32'd0);
        expect_both(32'h0, 32'hAABB_CCDD);
        expect_both(32'h4, 32'h0102_0304);
        expect_both(32'h8, 32'hFFFF_FFFF);
        send_word(32'hAABB_CCDD);
        send_word(32'h0102_0304);
        send_word(32'hFFFF_FFFF);
        cpu_addr_b = 12'h004;
        cpu_addr_s = 4'h4;
        tick();
        @(negedge clk);
        chk("run_done",  {31'd0, done_b},  32'd1);
        chk("run_stall", {31'd0, stall_b}, 32'd0);
        chk("run_wc",    {21'd0, wc_b},    32'd3);
        chk("run_addr",  {20'd0, addr_b},  32'h004);
        chk("run_we",    {31'd0, we_b},    32'd0);
        chk("run_done_s", {31'd0, done_s}, 32'd1);
        cpu_addr_b = 12'h7F8;
        #1;
        chk("run_addr2", {20'd0, addr_b}, 32'h7F8);
        send_word(32'h9999_9999);
        tick();
        chk("run_ignore_wc", {21'd0, wc_b}, 32'd3);

        // Overflow on the 4-bit-address instance only
        pulse_start();
        expect_both(32'h0, 32'h1111_1111);
        expect_both(32'h4, 32'h2222_2222);
        expect_both(32'h8, 32'h3333_3333);
        expect_both(32'hC, 32'h4444_4444);
        send_word(32'h1111_1111);
        send_word(32'h2222_2222);
        send_word(32'h3333_3333);
        send_word(32'h4444_4444);
        repeat (2) tick();
        @(negedge clk);
        chk("ovf_error_s", {31'd0, err_s},   32'd1);
        chk("ovf_stall_s", {31'd0, stall_s}, 32'd1);
        chk("ovf_wc_s",    {29'd0, wc_s},    32'd4);
        chk("ovf_addr_s",  {28'd0, addr_s},  32'hC);
        chk("ovf_error_b", {31'd0, err_b},   32'd0);
        q_b.push_back('{addr: 32'h10, data: 32'h5555_5555});
        send_word(32'h5555_5555);
        repeat (2) tick();
        @(negedge clk);
        chk("ovf_wc_s_hold", {29'd0, wc_s}, 32'd4);
        chk("ovf_error_s2",  {31'd0, err_s}, 32'd1);
        chk("ovf_wc_b",      {21'd0, wc_b}, 32'd5);

        // Restart mid-word discards the partial word
        pulse_start();
        @(negedge clk);
        chk("restart_err_clr", {31'd0, err_s}, 32'd0);
        send_byte(8'hAA);
        send_byte(8'hBB);
        pulse_start();
        expect_both(32'h0, 32'hDEAD_BEEF);
        send_word(32'hDEAD_BEEF);
        repeat (2) tick();
        @(negedge clk);
        chk("partial_wc", {21'd0, wc_b}, 32'd1);

        // Start in RUN together with a byte: start wins, byte dropped
        pulse_start();
        expect_both(32'h0, 32'hFFFF_FFFF);
        send_word(32'hFFFF_FFFF);
        tick();
        @(negedge clk);
        chk("run2_done", {31'd0, done_b}, 32'd1);
        start_load = 1'b1;
        rx_data    = 8'h99;
        rx_valid   = 1'b1;
        tick();
        start_load = 1'b0;
        rx_valid   = 1'b0;
        @(negedge clk);
        chk("rs_done",  {31'd0, done_b},  32'd0);
        chk("rs_stall", {31'd0, stall_b}, 32'd1);
        chk("rs_wc",    {21'd0, wc_b},    32'd0);
        expect_both(32'h0, 32'h0102_0304);
        send_word(32'h0102_0304);
        repeat (2) tick();
        @(negedge clk);
        chk("rs_wc2",  {21'd0, wc_b},   32'd1);
        chk("rs_done2", {31'd0, done_b}, 32'd0);

        // Every expected write must have been seen
        chk("q_big_empty",   q_b.size(), 32'd0);
        chk("q_small_empty", q_s.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
